pbkdf2_dk_ctrl: RTL and testbench
=================================

Name: pbkdf2_dk_ctrl

Overview:
Parametrised successor to the single-block pbkdf2 core. It produces multi-block PBKDF2-HMAC-SHA256 derived keys of 1..MAX_BLOCKS_P 256-bit blocks and supports variable password and salt lengths. It drives an external HMAC-SHA256 engine over a valid/ready request/response port, XOR-accumulates each T_i, and streams the key blocks out in order, one per handshake.

Parameters:
PASS_W_P, 512, password bus width in bits (multiple of 8)
SALT_W_P, 512, salt bus width in bits (multiple of 8, ≥ 224)
ITER_W_P, 32, iteration-count width
MAX_BLOCKS_P, 4, max derived-key blocks per request (≥1)
MSG_W_P, SALT_W_P+32, HMAC message bus width (must be ≥ 256)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active-low
in_valid  in  1  request valid
in_ready  out  1  controller idle, accepts request
pass_i  in  PASS_W_P  password, byte 0 at MSBs
pass_len_i  in  $clog2(PASS_W_P/8+1)  password length in bytes
salt_i  in  SALT_W_P  salt, byte 0 at MSBs
salt_len_i  in  $clog2(SALT_W_P/8+1)  salt length in bytes
iters_i  in  ITER_W_P  iteration count c
blocks_i  in  $clog2(MAX_BLOCKS_P+1)  number of 256-bit blocks
hmac_v_o  out  1  HMAC request valid
hmac_ready_i  in  1  HMAC engine accepts request
hmac_key_o  out  PASS_W_P  HMAC key (latched password)
hmac_key_len_o  out  $clog2(PASS_W_P/8+1)  key length in bytes
hmac_msg_o  out  MSG_W_P  HMAC message, byte 0 at MSBs
hmac_msg_len_o  out  $clog2(MSG_W_P/8+1)  message length in bytes
hmac_v_i  in  1  HMAC result valid
hmac_yumi_o  out  1  result consumed
hmac_hash_i  in  256  HMAC result
out_valid  out  1  key block valid
out_ready  in  1  downstream accepts block
key_o  out  256  derived-key block T_i
key_idx_o  out  $clog2(MAX_BLOCKS_P+1)  block index i (1-based)
key_last_o  out  1  final block of request

Behaviour:
- Reset (rst_ni=0 at posedge): state IDLE. hmac_v_o=0, hmac_yumi_o=0, out_valid=0, key_o=0, key_idx_o=0, key_last_o=0. in_ready=0 while rst_ni=0 and 1 in the first cycle after release. Reset mid-operation aborts the request silently; an in-flight HMAC result is ignored.
- States: IDLE, REQ, RESP, OUT.
- IDLE: in_ready=1. On in_valid, latch all inputs and set i=1, j=1, then go to REQ. Clamps applied at latch: iters 0→1; blocks 0→1; blocks>MAX_BLOCKS_P→MAX_BLOCKS_P; salt_len>SALT_W_P/8→SALT_W_P/8; pass_len>PASS_W_P/8→PASS_W_P/8.
- REQ: hmac_v_o=1 with stable key, message and length fields until hmac_ready_i. Handshake completes in the same cycle, then go to RESP. First hmac_v_o is asserted the cycle after input acceptance.
- Message when j=1: salt bytes 0..salt_len-1, then INT(i) as 32-bit big-endian, left-aligned; bytes beyond salt_len+4 are zero; length=salt_len+4.
- Message when j>1: U_{j-1} in the top 256 bits, remainder zero; length=32.
- RESP: hmac_yumi_o=hmac_v_i (combinational). On hmac_v_i: U←hash, T←(j==1 ? hash : T^hash). If j==iters go to OUT, else j←j+1 and go to REQ.
- OUT: out_valid=1, key_o=T, key_idx_o=i, key_last_o=(i==blocks). On out_ready: if last, go to IDLE (in_ready=1 the next cycle); else i←i+1, j←1, go to REQ. Outputs are held stable while out_valid && !out_ready.
- Counter j uses ITER_W_P bits; iters=2^ITER_W_P-1 must terminate without wrap.
- hmac_hash_i is ignored outside RESP. in_valid is ignored outside IDLE.

Test Plan:
- Real HMAC core, P="password" (8), S="salt" (4), c=1, blocks=1 -> key_o=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b, key_last_o=1, key_idx_o=1.
- Same request with c=2 -> ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43. With c=4096 -> c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a, and exactly 4096 HMAC handshakes.
- Mock HMAC, S="salt", blocks=3, c=2 -> first-request messages 73616c7400000001, ...02, ...03 (length 8); key_idx_o 1,2,3; key_last_o only on idx 3; 6 HMAC handshakes total.
- Backpressure: hmac_ready_i low 5 cycles, then out_ready low 7 cycles -> request and key fields stable throughout; no duplicate or dropped block.
- Clamps: iters=0 or blocks=0 -> behaves as 1 (single HMAC, one output block); blocks=7 with MAX_BLOCKS_P=4 -> 4 blocks output.
- rst_ni pulsed low in RESP while hmac_v_i=1 -> next cycle out_valid=0, hmac_yumi_o=0; in_ready=1 after release; new request completes correctly.

Source files
------------

// File: rtl/pbkdf2_dk_ctrl.sv
// PBKDF2-HMAC-SHA256 derived-key controller: drives an external HMAC engine for
// c iterations per block, XOR-accumulates T_i and streams 1..MAX_BLOCKS_P blocks.
module pbkdf2_dk_ctrl #(
  parameter int unsigned PASS_W_P     = 512,
  parameter int unsigned SALT_W_P     = 512,
  parameter int unsigned ITER_W_P     = 32,
  parameter int unsigned MAX_BLOCKS_P = 4,
  parameter int unsigned MSG_W_P      = SALT_W_P + 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PASS_W_P-1:0]               pass_i,
  input  logic [$clog2(PASS_W_P/8+1)-1:0]   pass_len_i,
  input  logic [SALT_W_P-1:0]               salt_i,
  input  logic [$clog2(SALT_W_P/8+1)-1:0]   salt_len_i,
  input  logic [ITER_W_P-1:0]               iters_i,
  input  logic [$clog2(MAX_BLOCKS_P+1)-1:0] blocks_i,
  output logic                              hmac_v_o,
  input  logic                              hmac_ready_i,
  output logic [PASS_W_P-1:0]               hmac_key_o,
  output logic [$clog2(PASS_W_P/8+1)-1:0]   hmac_key_len_o,
  output logic [MSG_W_P-1:0]                hmac_msg_o,
  output logic [$clog2(MSG_W_P/8+1)-1:0]    hmac_msg_len_o,
  input  logic                              hmac_v_i,
  output logic                              hmac_yumi_o,
  input  logic [255:0]                      hmac_hash_i,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [255:0]                      key_o,
  output logic [$clog2(MAX_BLOCKS_P+1)-1:0] key_idx_o,
  output logic                              key_last_o
);

  localparam int unsigned PLEN_W = $clog2(PASS_W_P/8+1);
  localparam int unsigned SLEN_W = $clog2(SALT_W_P/8+1);
  localparam int unsigned MLEN_W = $clog2(MSG_W_P/8+1);
  localparam int unsigned BLK_W  = $clog2(MAX_BLOCKS_P+1);
  localparam int unsigned PASS_B = PASS_W_P / 8;
  localparam int unsigned SALT_B = SALT_W_P / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_e;

  state_e               state_q, state_d;
  logic [PASS_W_P-1:0]  pass_q, pass_d;
  logic [PLEN_W-1:0]    pass_len_q, pass_len_d;
  logic [SALT_W_P-1:0]  salt_q, salt_d;
  logic [SLEN_W-1:0]    salt_len_q, salt_len_d;
  logic [ITER_W_P-1:0]  iters_q, iters_d;
  logic [BLK_W-1:0]     blocks_q, blocks_d;
  logic [BLK_W-1:0]     i_q, i_d;
  logic [ITER_W_P-1:0]  j_q, j_d;
  logic [255:0]         u_q, u_d;
  logic [255:0]         t_q, t_d;

  logic [PLEN_W-1:0]    pass_len_c;
  logic [SLEN_W-1:0]    salt_len_c;
  logic [ITER_W_P-1:0]  iters_c;
  logic [BLK_W-1:0]     blocks_c;
  logic [SALT_W_P-1:0]  salt_ones;
  logic [SALT_W_P-1:0]  salt_mask;
  logic [31:0]          blk_be;
  logic [MSG_W_P-1:0]   msg_salt, msg_int, msg_u;
  logic                 first_iter;

  // Input clamps applied at acceptance.
  assign pass_len_c = (pass_len_i > PLEN_W'(PASS_B)) ? PLEN_W'(PASS_B) : pass_len_i;
  assign salt_len_c = (salt_len_i > SLEN_W'(SALT_B)) ? SLEN_W'(SALT_B) : salt_len_i;
  assign iters_c    = (iters_i == '0) ? ITER_W_P'(1) : iters_i;
  assign blocks_c   = (blocks_i == '0)                  ? BLK_W'(1) :
                      (blocks_i > BLK_W'(MAX_BLOCKS_P)) ? BLK_W'(MAX_BLOCKS_P) : blocks_i;

  // Salt bytes past salt_len are zeroed once at latch so INT(i) can be OR-ed in.
  assign salt_ones = '1;
  assign salt_mask = ~(salt_ones >> {salt_len_c, 3'b000});

  assign first_iter = (j_q == ITER_W_P'(1));
  assign blk_be     = 32'(i_q);
  assign msg_salt   = MSG_W_P'(salt_q) << (MSG_W_P - SALT_W_P);
  assign msg_int    = (MSG_W_P'(blk_be) << (MSG_W_P - 32)) >> {salt_len_q, 3'b000};
  assign msg_u      = MSG_W_P'(u_q) << (MSG_W_P - 256);

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    pass_len_d = pass_len_q;
    salt_d     = salt_q;
    salt_len_d = salt_len_q;
    iters_d    = iters_q;
    blocks_d   = blocks_q;
    i_d        = i_q;
    j_d        = j_q;
    u_d        = u_q;
    t_d        = t_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pass_d     = pass_i;
          pass_len_d = pass_len_c;
          salt_d     = salt_i & salt_mask;
          salt_len_d = salt_len_c;
          iters_d    = iters_c;
          blocks_d   = blocks_c;
          i_d        = BLK_W'(1);
          j_d        = ITER_W_P'(1);
          state_d    = REQ;
        end
      end
      REQ: begin
        if (hmac_ready_i) state_d = RESP;
      end
      RESP: begin
        if (hmac_v_i) begin
          u_d = hmac_hash_i;
          t_d = first_iter ? hmac_hash_i : (t_q ^ hmac_hash_i);
          // j is only incremented when below iters, so it never wraps.
          if (j_q == iters_q) begin
            state_d = OUT;
          end else begin
            j_d     = j_q + ITER_W_P'(1);
            state_d = REQ;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          if (i_q == blocks_q) begin
            state_d = IDLE;
          end else begin
            i_d     = i_q + BLK_W'(1);
            j_d     = ITER_W_P'(1);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pass_q     <= '0;
      pass_len_q <= '0;
      salt_q     <= '0;
      salt_len_q <= '0;
      iters_q    <= '0;
      blocks_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      u_q        <= '0;
      t_q        <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      pass_len_q <= pass_len_d;
      salt_q     <= salt_d;
      salt_len_q <= salt_len_d;
      iters_q    <= iters_d;
      blocks_q   <= blocks_d;
      i_q        <= i_d;
      j_q        <= j_d;
      u_q        <= u_d;
      t_q        <= t_d;
    end
  end

  assign in_ready       = (state_q == IDLE) && rst_ni;
  assign hmac_v_o       = (state_q == REQ);
  assign hmac_yumi_o    = (state_q == RESP) && hmac_v_i;
  assign hmac_key_o     = pass_q;
  assign hmac_key_len_o = pass_len_q;
  assign hmac_msg_o     = first_iter ? (msg_salt | msg_int) : msg_u;
  assign hmac_msg_len_o = first_iter ? (MLEN_W'(salt_len_q) + MLEN_W'(4)) : MLEN_W'(32);
  assign out_valid      = (state_q == OUT);
  assign key_o          = out_valid ? t_q : '0;
  assign key_idx_o      = out_valid ? i_q : '0;
  assign key_last_o     = out_valid && (i_q == blocks_q);

endmodule

// File: tb/tb_pbkdf2_dk_ctrl.sv
// Directed bench for pbkdf2_dk_ctrl: behavioural HMAC-SHA256 responder plus a
// reference PBKDF2 model and RFC known-answer vectors.
module tb_pbkdf2_dk_ctrl;

  localparam int PW  = 512;
  localparam int SW  = 512;
  localparam int IW  = 32;
  localparam int MB  = 4;
  localparam int MW  = SW + 32;
  localparam int PLW = $clog2(PW/8+1);
  localparam int SLW = $clog2(SW/8+1);
  localparam int MLW = $clog2(MW/8+1);
  localparam int BW  = $clog2(MB+1);

  localparam logic [255:0] C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [255:0] C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;
  localparam logic [PW-1:0] PASS = {64'h70617373776f7264, {14{32'hdeadbeef}}};
  localparam logic [SW-1:0] SALT = {32'h73616c74, {15{32'ha5a5c3c3}}};

  localparam logic [31:0] K_C [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic            clk_i;
  logic            rst_ni;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   pass_i;
  logic [PLW-1:0]  pass_len_i;
  logic [SW-1:0]   salt_i;
  logic [SLW-1:0]  salt_len_i;
  logic [IW-1:0]   iters_i;
  logic [BW-1:0]   blocks_i;
  logic            hmac_v_o;
  logic            hmac_ready_i;
  logic [PW-1:0]   hmac_key_o;
  logic [PLW-1:0]  hmac_key_len_o;
  logic [MW-1:0]   hmac_msg_o;
  logic [MLW-1:0]  hmac_msg_len_o;
  logic            hmac_v_i;
  logic            hmac_yumi_o;
  logic [255:0]    hmac_hash_i;
  logic            out_valid;
  logic            out_ready;
  logic [255:0]    key_o;
  logic [BW-1:0]   key_idx_o;
  logic            key_last_o;

  pbkdf2_dk_ctrl #(
    .PASS_W_P(PW), .SALT_W_P(SW), .ITER_W_P(IW), .MAX_BLOCKS_P(MB), .MSG_W_P(MW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid(in_valid), .in_ready(in_ready),
    .pass_i(pass_i), .pass_len_i(pass_len_i), .salt_i(salt_i), .salt_len_i(salt_len_i),
    .iters_i(iters_i), .blocks_i(blocks_i),
    .hmac_v_o(hmac_v_o), .hmac_ready_i(hmac_ready_i), .hmac_key_o(hmac_key_o),
    .hmac_key_len_o(hmac_key_len_o), .hmac_msg_o(hmac_msg_o), .hmac_msg_len_o(hmac_msg_len_o),
    .hmac_v_i(hmac_v_i), .hmac_yumi_o(hmac_yumi_o), .hmac_hash_i(hmac_hash_i),
    .out_valid(out_valid), .out_ready(out_ready), .key_o(key_o), .key_idx_o(key_idx_o),
    .key_last_o(key_last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SHA-256 / HMAC-SHA256 behavioural model
  logic [7:0] sbuf [0:255];
  logic [7:0] kb [0:63];
  logic [7:0] mb [0:127];
  int klen;
  int mlen;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256(input int n);
    logic [7:0]  p [0:255];
    logic [31:0] h [0:7];
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    logic [63:0] bits;
    int tot;
    for (int k = 0; k < 256; k++) p[k] = (k < n) ? sbuf[k] : 8'h00;
    p[n] = 8'h80;
    tot  = ((n + 8) / 64 + 1) * 64;
    bits = 64'(n) * 64'd8;
    for (int k = 0; k < 8; k++) p[tot-1-k] = bits[8*k +: 8];
    h[0] = 32'h6a09e667; h[1] = 32'hbb67ae85; h[2] = 32'h3c6ef372; h[3] = 32'ha54ff53a;
    h[4] = 32'h510e527f; h[5] = 32'h9b05688c; h[6] = 32'h1f83d9ab; h[7] = 32'h5be0cd19;
    for (int blk = 0; blk < tot; blk += 64) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[blk+4*t], p[blk+4*t+1], p[blk+4*t+2], p[blk+4*t+3]};
      for (int t = 16; t < 64; t++) begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_C[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic logic [255:0] hmac_bytes();
    logic [255:0] inner;
    for (int k = 0; k < 64; k++) sbuf[k] = ((k < klen) ? kb[k] : 8'h00) ^ 8'h36;
    for (int k = 0; k < mlen; k++) sbuf[64+k] = mb[k];
    inner = sha256(64 + mlen);
    for (int k = 0; k < 64; k++) sbuf[k] = ((k < klen) ? kb[k] : 8'h00) ^ 8'h5c;
    for (int k = 0; k < 32; k++) sbuf[64+k] = inner[255-8*k -: 8];
    return sha256(96);
  endfunction

  logic [255:0] ref_q [$];

  task automatic ref_pbkdf2(input logic [PW-1:0] pw, input int pl, input logic [SW-1:0] s,
                            input int sl, input int c, input int nb);
    logic [255:0] u;
    logic [255:0] t;
    logic [31:0]  bv;
    ref_q.delete();
    for (int bi = 1; bi <= nb; bi++) begin
      for (int k = 0; k < 64; k++) kb[k] = pw[PW-1-8*k -: 8];
      klen = pl;
      for (int k = 0; k < sl; k++) mb[k] = s[SW-1-8*k -: 8];
      bv = 32'(bi);
      for (int k = 0; k < 4; k++) mb[sl+k] = bv[31-8*k -: 8];
      mlen = sl + 4;
      u = hmac_bytes();
      t = u;
      for (int j = 2; j <= c; j++) begin
        for (int k = 0; k < 32; k++) mb[k] = u[255-8*k -: 8];
        mlen = 32;
        u = hmac_bytes();
        t = t ^ u;
      end
      ref_q.push_back(t);
    end
  endtask

  // HMAC engine responder
  bit            rst_seen;
  bit            fire_seen;
  bit            yumi_seen;
  bit            pending;
  bit            rsnap;
  int            rdy_hold;
  int            hs_cnt;
  logic [255:0]  res;
  logic [MW-1:0] cap_msg;
  int            cap_len;
  logic [MW-1:0] s_msg;
  logic [PW-1:0] s_key;
  int            s_mlen;
  int            s_klen;
  logic [MW-1:0] msg_log [$];
  int            len_log [$];
  int            klen_log [$];

  initial begin
    forever begin
      @(posedge clk_i);
      rst_seen = rst_ni;
    end
  end

  initial begin
    hmac_ready_i = 1'b1;
    hmac_v_i     = 1'b0;
    hmac_hash_i  = '0;
    pending = 0; fire_seen = 0; yumi_seen = 0; rsnap = 0; rdy_hold = 0; hs_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_seen) begin
        pending = 0; fire_seen = 0; yumi_seen = 0; rsnap = 0;
      end else begin
        if (yumi_seen) pending = 0;
        if (fire_seen) begin
          for (int k = 0; k < 64; k++) kb[k] = s_key[PW-1-8*k -: 8];
          klen = s_klen;
          for (int k = 0; k < MW/8; k++) mb[k] = cap_msg[MW-1-8*k -: 8];
          mlen = cap_len;
          res = hmac_bytes();
          pending = 1;
        end
      end
      fire_seen = 0;
      yumi_seen = 0;
      hmac_v_i    = pending;
      hmac_hash_i = pending ? res : {8{$urandom}};
      hmac_ready_i = !(hmac_v_o && rdy_hold > 0);
      if (hmac_v_o && rdy_hold > 0) rdy_hold--;
      #1;
      fire_seen = rst_ni && hmac_v_o && hmac_ready_i;
      yumi_seen = hmac_yumi_o;
      if (rst_ni && hmac_v_o) begin
        if (!rsnap) begin
          rsnap = 1; s_msg = hmac_msg_o; s_key = hmac_key_o;
          s_mlen = int'(hmac_msg_len_o); s_klen = int'(hmac_key_len_o);
        end else begin
          check_eq("req_msg_stable", hmac_msg_o, s_msg);
          check_eq("req_key_stable", hmac_key_o, s_key);
          check_eq("req_mlen_stable", hmac_msg_len_o, s_mlen);
          check_eq("req_klen_stable", hmac_key_len_o, s_klen);
        end
      end
      if (fire_seen) begin
        cap_msg = hmac_msg_o;
        cap_len = int'(hmac_msg_len_o);
        hs_cnt++;
        msg_log.push_back(hmac_msg_o);
        len_log.push_back(cap_len);
        klen_log.push_back(s_klen);
        rsnap = 0;
      end
    end
  end

  // Request / output-side tasks
  logic [255:0] got_key [$];
  int           got_idx [$];
  int           got_last [$];
  int           ostall = 0;

  task automatic send(input logic [PW-1:0] pw, input int pl, input logic [SW-1:0] s, input int sl,
                      input logic [IW-1:0] c, input int nb);
    int cyc = 0;
    hs_cnt = 0;
    msg_log.delete(); len_log.delete(); klen_log.delete();
    got_key.delete(); got_idx.delete(); got_last.delete();
    @(negedge clk_i);
    while (!in_ready && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!in_ready) check_eq("accept_timeout", 0, 1);
    pass_i = pw; pass_len_i = PLW'(pl); salt_i = s; salt_len_i = SLW'(sl);
    iters_i = c; blocks_i = BW'(nb); in_valid = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
    pass_i = {16{$urandom}}; salt_i = {16{$urandom}}; iters_i = '1; blocks_i = '1;
    check_eq("req_after_accept", hmac_v_o, 1);
  endtask

  task automatic collect(input int budget);
    int cyc = 0;
    bit done = 0;
    bit osnap = 0;
    logic [255:0] sk;
    int si;
    int sl;
    while (!done && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
      out_ready = 1'b0;
      if (out_valid) begin
        if (ostall > 0) begin
          if (osnap) begin
            check_eq("out_key_stable", key_o, sk);
            check_eq("out_idx_stable", key_idx_o, si);
            check_eq("out_last_stable", key_last_o, sl);
          end else begin
            osnap = 1; sk = key_o; si = int'(key_idx_o); sl = int'(key_last_o);
          end
          ostall--;
        end else begin
          out_ready = 1'b1;
          osnap = 0;
          got_key.push_back(key_o);
          got_idx.push_back(int'(key_idx_o));
          got_last.push_back(int'(key_last_o));
          if (key_last_o) done = 1;
        end
      end
    end
    if (!done) check_eq("out_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    out_ready = 1'b0;
    if (done) check_eq("idle_after_last", in_ready, 1);
  endtask

  task automatic check_blocks(input string tag, input int nb);
    check_eq({tag, "_nblk"}, got_key.size(), nb);
    for (int k = 0; k < nb; k++) begin
      if (k < got_key.size()) begin
        check_eq({tag, "_key"}, got_key[k], ref_q[k]);
        check_eq({tag, "_idx"}, got_idx[k], k + 1);
        check_eq({tag, "_last"}, got_last[k], (k == nb - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  logic [MW-1:0] em;

  initial begin
    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pass_i = '0; pass_len_i = '0; salt_i = '0; salt_len_i = '0; iters_i = '0; blocks_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_hmac_v", hmac_v_o, 0);
    check_eq("rst_yumi", hmac_yumi_o, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_key", key_o, 0);
    check_eq("rst_idx", key_idx_o, 0);
    check_eq("rst_last", key_last_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("rel_in_ready", in_ready, 1);

    // RFC known answers
    send(PASS, 8, SALT, 4, 1, 1);
    collect(200);
    ref_q.delete(); ref_q.push_back(C1);
    check_blocks("c1", 1);
    check_eq("c1_hs", hs_cnt, 1);

    send(PASS, 8, SALT, 4, 2, 1);
    collect(200);
    ref_q.delete(); ref_q.push_back(C2);
    check_blocks("c2", 1);
    check_eq("c2_hs", hs_cnt, 2);

    send(PASS, 8, SALT, 4, 4096, 1);
    collect(20000);
    ref_q.delete(); ref_q.push_back(C4096);
    check_blocks("c4096", 1);
    check_eq("c4096_hs", hs_cnt, 4096);

    // Three blocks, two iterations: message layout and block sequencing
    send(PASS, 8, SALT, 4, 2, 3);
    collect(500);
    ref_pbkdf2(PASS, 8, SALT, 4, 2, 3);
    check_blocks("b3", 3);
    check_eq("b3_hs", hs_cnt, 6);
    for (int bi = 1; bi <= 3; bi++) begin
      if (msg_log.size() >= 2 * bi) begin
        em = '0;
        em[MW-1 -: 64] = {32'h73616c74, 32'(bi)};
        check_eq("b3_msg_first", msg_log[2*bi-2], em);
        check_eq("b3_len_first", len_log[2*bi-2], 8);
        check_eq("b3_len_chain", len_log[2*bi-1], 32);
        check_eq("b3_chain_tail", msg_log[2*bi-1][MW-257:0], 0);
      end
    end

    // Backpressure on both handshakes
    rdy_hold = 5;
    ostall = 7;
    send(PASS, 8, SALT, 4, 2, 2);
    collect(500);
    ref_pbkdf2(PASS, 8, SALT, 4, 2, 2);
    check_blocks("bp", 2);
    check_eq("bp_hs", hs_cnt, 4);

    // Clamps
    send(PASS, 8, SALT, 4, 0, 1);
    collect(200);
    ref_q.delete(); ref_q.push_back(C1);
    check_blocks("it0", 1);
    check_eq("it0_hs", hs_cnt, 1);

    send(PASS, 8, SALT, 4, 1, 0);
    collect(200);
    check_blocks("bk0", 1);

    send(PASS, 8, SALT, 4, 1, 7);
    collect(500);
    ref_pbkdf2(PASS, 8, SALT, 4, 1, 4);
    check_blocks("bk7", 4);
    check_eq("bk7_hs", hs_cnt, 4);

    send({16{32'h5a17c0de}}, 100, {16{32'h9e3779b9}}, 100, 1, 1);
    collect(200);
    ref_pbkdf2({16{32'h5a17c0de}}, 64, {16{32'h9e3779b9}}, 64, 1, 1);
    check_blocks("len", 1);
    if (len_log.size() > 0) begin
      check_eq("len_msg_clamp", len_log[0], 68);
      check_eq("len_key_clamp", klen_log[0], 64);
    end

    // Reset while a result is being presented
    send(PASS, 8, SALT, 4, 3, 1);
    begin
      int cyc = 0;
      bit hit = 0;
      while (!hit && cyc < 50) begin
        @(negedge clk_i);
        #2;
        cyc++;
        if (hmac_v_i && hmac_yumi_o) hit = 1;
      end
      check_eq("rst_resp_seen", hit, 1);
    end
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_yumi", hmac_yumi_o, 0);
    check_eq("mid_rst_hmac_v", hmac_v_o, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("mid_rel_in_ready", in_ready, 1);
    send(PASS, 8, SALT, 4, 2, 1);
    collect(200);
    ref_q.delete(); ref_q.push_back(C2);
    check_blocks("after_rst", 1);
    check_eq("after_rst_hs", hs_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
